// File: rtl/wbarb_pkg.sv
// Shared helpers for the writeback arbiter.
// Pure combinational utilities; no state, no handshakes.
package wbarb_pkg;

    localparam int WB_DEF_WIDTH  = 64;
    localparam int WB_DEF_DEPTH  = 64;
    localparam int WB_DEF_SRCS   = 4;
    localparam int WB_DEF_WPORTS = 2;
    localparam int WB_DEF_QDEPTH = 2;

    // Source visited at scan position 'off' when the scan starts at 'base'.
    function automatic int rr_idx(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/wbarb_wbq.sv
// Per-source result queue: circular buffer with read/write pointers and occupancy count.
// Latency: a push is visible on dout the cycle after; ready is from the registered count only.
module wbq #(
    parameter int dw     = 70,
    parameter int qdepth = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [dw-1:0] din,
    output logic [dw-1:0] dout,
    output logic          empty,
    output logic          ready
);
    import wbarb_pkg::*;

    localparam int pw = $clog2(qdepth);
    localparam int cw = pw + 1;

    logic [dw-1:0] mem [qdepth];
    logic [pw-1:0] wptr;
    logic [pw-1:0] rptr;
    logic [cw-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign ready   = (count != cw'(qdepth));
    assign empty   = (count == '0);
    assign dout    = mem[rptr];
    assign do_push = push & ready;
    assign do_pop  = pop & ~empty;

    // Pointers wrap for free because qdepth is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

endmodule

// File: rtl/wbarb.sv
// Writeback arbiter: per-source queues feed up to wports distinct-address register file writes per cycle.
// Latency: 2 cycles handshake to wena; a producer stalls only when its own queue is full.
module wbarb #(
    parameter int width  = 64,
    parameter int depth  = 64,
    parameter int srcs   = 4,
    parameter int wports = 2,
    parameter int qdepth = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [srcs-1:0]                       src_valid,
    output logic [srcs-1:0]                       src_ready,
    input  logic [srcs-1:0][$clog2(depth)-1:0]    src_addr,
    input  logic [srcs-1:0][width-1:0]            src_value,
    output logic [wports-1:0][$clog2(depth)-1:0]  waddr,
    output logic [wports-1:0][width-1:0]          wvalue,
    output logic [wports-1:0]                     wena,
    output logic                                  idle
);
    import wbarb_pkg::*;

    localparam int aw = $clog2(depth);
    localparam int sw = (srcs > 1) ? $clog2(srcs) : 1;

    typedef struct packed {
        logic [aw-1:0]    addr;
        logic [width-1:0] value;
    } wbreq_t;

    wbreq_t            head     [srcs];
    logic [srcs-1:0]   q_empty;
    logic [srcs-1:0]   grant;
    wbreq_t            port_req [wports];
    logic [wports-1:0] port_vld;
    logic [sw-1:0]     rr;
    logic [sw-1:0]     last_g;
    logic [sw-1:0]     rr_nxt;

    for (genvar i = 0; i < srcs; i++) begin : g_q
        wbq #(
            .dw     ($bits(wbreq_t)),
            .qdepth (qdepth)
        ) u_q (
            .clk   (clk),
            .rst   (rst),
            .push  (src_valid[i]),
            .pop   (grant[i]),
            .din   ({src_addr[i], src_value[i]}),
            .dout  (head[i]),
            .empty (q_empty[i]),
            .ready (src_ready[i])
        );
    end

    // Scan from rr; a head whose address is already granted this cycle waits for the next one.
    always_comb begin
        logic [sw-1:0] s;
        logic          clash;
        int            gcnt;
        grant    = '0;
        port_vld = '0;
        for (int k = 0; k < wports; k++) port_req[k] = '0;
        last_g = rr;
        s      = '0;
        clash  = 1'b0;
        gcnt   = 0;
        for (int off = 0; off < srcs; off++) begin
            s = sw'(rr_idx(int'(rr), off, srcs));
            if (!q_empty[s] && gcnt < wports) begin
                clash = 1'b0;
                for (int k = 0; k < wports; k++) begin
                    if (port_vld[k] && port_req[k].addr == head[s].addr) clash = 1'b1;
                end
                if (!clash) begin
                    for (int k = 0; k < wports; k++) begin
                        if (k == gcnt) begin
                            port_vld[k] = 1'b1;
                            port_req[k] = head[s];
                        end
                    end
                    grant[s] = 1'b1;
                    last_g   = s;
                    gcnt     = gcnt + 1;
                end
            end
        end
    end

    assign rr_nxt = sw'(rr_idx(int'(last_g), 1, srcs));

    always_ff @(posedge clk) begin
        if (rst) begin
            rr     <= '0;
            wena   <= '0;
            waddr  <= '0;
            wvalue <= '0;
        end else begin
            wena <= port_vld;
            for (int k = 0; k < wports; k++) begin
                if (port_vld[k]) begin
                    waddr[k]  <= port_req[k].addr;
                    wvalue[k] <= port_req[k].value;
                end
            end
            if (|grant) rr <= rr_nxt;
        end
    end

    assign idle = (&q_empty) & ~(|wena);

endmodule

// File: tb/tb_wbarb.sv
// Bench for wbarb: directed vector table, hand sequences and random traffic against a queue model.
module tb_wbarb;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [3:0]           src_valid;
    logic [3:0]           src_ready;
    logic [3:0][5:0]      src_addr;
    logic [3:0][63:0]     src_value;
    logic [1:0][5:0]      waddr;
    logic [1:0][63:0]     wvalue;
    logic [1:0]           wena;
    logic                 idle;

    always #5 clk = ~clk;

    wbarb #(.width(64), .depth(64), .srcs(4), .wports(2), .qdepth(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src_addr  (src_addr),
        .src_value (src_value),
        .waddr     (waddr),
        .wvalue    (wvalue),
        .wena      (wena),
        .idle      (idle)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [5:0]  a;
        logic [63:0] v;
    } ent_t;

    ent_t            mq [4][$];
    int              rr_m;
    logic [1:0]      mw;
    logic [1:0][5:0] ma;
    logic [1:0][63:0] mv;
    logic [63:0]     wlog [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    function automatic logic m_idle();
        logic r;
        r = (mw == 2'b00);
        for (int i = 0; i < 4; i++) if (mq[i].size() != 0) r = 1'b0;
        return r;
    endfunction

    task automatic do_reset(input logic [3:0] vld);
        src_valid = vld;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        src_valid = '0;
        for (int i = 0; i < 4; i++) mq[i].delete();
        rr_m = 0;
        mw = '0;
        ma = '0;
        mv = '0;
    endtask

    // One clock of traffic: model predicts grants from queue heads and checks every output.
    task automatic cycle(input logic [3:0] vld, input logic [3:0][5:0] a,
                         input logic [3:0][63:0] v, output logic [3:0] acc);
        logic [3:0] rdy;
        logic [3:0] gs;
        logic [1:0] gw;
        ent_t       ge [2];
        int         g;
        int         last;
        int         s;
        logic       ok;
        for (int i = 0; i < 4; i++) rdy[i] = (mq[i].size() != 2);
        chk("src_ready", 64'(src_ready), 64'(rdy));
        src_valid = vld;
        src_addr  = a;
        src_value = v;
        acc = vld & src_ready;
        gs = '0; gw = '0; g = 0; last = -1;
        ge[0] = '0; ge[1] = '0;
        for (int off = 0; off < 4; off++) begin
            s = (rr_m + off) % 4;
            if (mq[s].size() > 0 && g < 2) begin
                ok = 1'b1;
                for (int k = 0; k < g; k++) if (ge[k].a == mq[s][0].a) ok = 1'b0;
                if (ok) begin
                    ge[g] = mq[s][0];
                    gw[g] = 1'b1;
                    gs[s] = 1'b1;
                    last = s;
                    g++;
                end
            end
        end
        @(posedge clk);
        for (int i = 0; i < 4; i++) if (gs[i]) void'(mq[i].pop_front());
        for (int i = 0; i < 4; i++) if (vld[i] && rdy[i]) mq[i].push_back({a[i], v[i]});
        for (int k = 0; k < 2; k++) begin
            mw[k] = gw[k];
            if (gw[k]) begin
                ma[k] = ge[k].a;
                mv[k] = ge[k].v;
            end
        end
        if (last >= 0) rr_m = (last + 1) % 4;
        #1;
        chk("wena", 64'(wena), 64'(mw));
        chk("waddr0", 64'(waddr[0]), 64'(ma[0]));
        chk("waddr1", 64'(waddr[1]), 64'(ma[1]));
        chk("wvalue0", wvalue[0], mv[0]);
        chk("wvalue1", wvalue[1], mv[1]);
        chk("idle", 64'(idle), 64'(m_idle()));
        for (int k = 0; k < 2; k++) if (wena[k]) wlog.push_back(wvalue[k]);
        if (wena == 2'b11) chk("dup_waddr", 64'(waddr[0] != waddr[1]), 64'd1);
    endtask

    typedef struct {
        logic [3:0]       vld;
        logic [3:0][5:0]  a;
        logic [3:0][63:0] v;
        logic [1:0]       w1;
        logic [1:0][5:0]  a1;
        logic [1:0][63:0] v1;
        logic [1:0]       w2;
        logic [1:0][5:0]  a2;
        logic [1:0][63:0] v2;
    } vec_t;

    vec_t vt [5];

    initial begin
        logic [3:0]       acc;
        logic [3:0][5:0]  a;
        logic [3:0][63:0] v;
        int               seq [4];
        int               acc_idx;
        logic [63:0]      s1 [$];

        vt[0] = '{4'b0100, {6'd0, 6'd5, 6'd0, 6'd0}, {64'h0, 64'hAB, 64'h0, 64'h0},
                  2'b01, {6'd0, 6'd5}, {64'h0, 64'hAB},
                  2'b00, {6'd0, 6'd5}, {64'h0, 64'hAB}};
        vt[1] = '{4'b1011, {6'd9, 6'd0, 6'd7, 6'd7}, {64'h13, 64'h0, 64'h11, 64'h10},
                  2'b11, {6'd9, 6'd7}, {64'h13, 64'h10},
                  2'b01, {6'd9, 6'd7}, {64'h13, 64'h11}};
        vt[2] = '{4'b1111, {6'd13, 6'd12, 6'd11, 6'd10}, {64'h23, 64'h22, 64'h21, 64'h20},
                  2'b11, {6'd11, 6'd10}, {64'h21, 64'h20},
                  2'b11, {6'd13, 6'd12}, {64'h23, 64'h22}};
        vt[3] = '{4'b1111, {6'd3, 6'd3, 6'd3, 6'd3}, {64'h33, 64'h32, 64'h31, 64'h30},
                  2'b01, {6'd0, 6'd3}, {64'h0, 64'h30},
                  2'b01, {6'd0, 6'd3}, {64'h0, 64'h31}};
        vt[4] = '{4'b1010, {6'd21, 6'd0, 6'd20, 6'd0}, {64'h43, 64'h0, 64'h41, 64'h0},
                  2'b11, {6'd21, 6'd20}, {64'h43, 64'h41},
                  2'b00, {6'd21, 6'd20}, {64'h43, 64'h41}};

        src_valid = '0;
        src_addr  = '0;
        src_value = '0;
        rst = 1'b1;

        // Reset state
        do_reset(4'b0000);
        chk("rst_wena", 64'(wena), 64'd0);
        chk("rst_src_ready", 64'(src_ready), 64'hF);
        chk("rst_idle", 64'(idle), 64'd1);
        chk("rst_waddr", 64'(waddr), 64'd0);
        chk("rst_wvalue0", wvalue[0], 64'd0);

        // Directed vector table
        for (int t = 0; t < 5; t++) begin
            do_reset(4'b0000);
            cycle(vt[t].vld, vt[t].a, vt[t].v, acc);
            cycle(4'b0000, '0, '0, acc);
            chk($sformatf("vec%0d_wena1", t), 64'(wena), 64'(vt[t].w1));
            chk($sformatf("vec%0d_waddr1", t), 64'(waddr), 64'(vt[t].a1));
            chk($sformatf("vec%0d_wvalue1_p0", t), wvalue[0], vt[t].v1[0]);
            chk($sformatf("vec%0d_wvalue1_p1", t), wvalue[1], vt[t].v1[1]);
            cycle(4'b0000, '0, '0, acc);
            chk($sformatf("vec%0d_wena2", t), 64'(wena), 64'(vt[t].w2));
            chk($sformatf("vec%0d_waddr2", t), 64'(waddr), 64'(vt[t].a2));
            chk($sformatf("vec%0d_wvalue2_p0", t), wvalue[0], vt[t].v2[0]);
            chk($sformatf("vec%0d_wvalue2_p1", t), wvalue[1], vt[t].v2[1]);
        end

        // Fairness: four continuously pushing sources alternate {0,1},{2,3}
        do_reset(4'b0000);
        for (int i = 0; i < 4; i++) seq[i] = 0;
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < 4; i++) begin
                a[i] = 6'(i * 8 + seq[i] % 8);
                v[i] = 64'(i * 256 + seq[i]);
            end
            cycle(4'b1111, a, v, acc);
            for (int i = 0; i < 4; i++) if (acc[i]) seq[i]++;
            if (c >= 1) begin
                chk("fair_wena", 64'(wena), 64'd3);
                chk("fair_src_p0", 64'(waddr[0][5:3]), ((c - 1) % 2 == 0) ? 64'd0 : 64'd2);
                chk("fair_src_p1", 64'(waddr[1][5:3]), ((c - 1) % 2 == 0) ? 64'd1 : 64'd3);
            end
        end

        // Backpressure: src 1 fills behind src 0's conflicting head
        do_reset(4'b0000);
        wlog.delete();
        cycle(4'b0011, {6'd0, 6'd0, 6'd8, 6'd8}, {64'h0, 64'h0, 64'h1A, 64'h801}, acc);
        cycle(4'b0011, {6'd0, 6'd0, 6'd8, 6'd8}, {64'h0, 64'h0, 64'h1B, 64'h802}, acc);
        chk("bp_ready1_low", 64'(src_ready[1]), 64'd0);
        acc_idx = -1;
        for (int c = 2; c < 8 && acc_idx < 0; c++) begin
            cycle(4'b0010, {6'd0, 6'd0, 6'd8, 6'd0}, {64'h0, 64'h0, 64'h1C, 64'h0}, acc);
            if (acc[1]) acc_idx = c;
        end
        chk("bp_accept_cycle", 64'(acc_idx), 64'd3);
        for (int c = 0; c < 6; c++) cycle(4'b0000, '0, '0, acc);
        foreach (wlog[i]) if (wlog[i] >= 64'h1A && wlog[i] <= 64'h1C) s1.push_back(wlog[i]);
        chk("bp_src1_count", 64'(s1.size()), 64'd3);
        if (s1.size() == 3) begin
            chk("bp_order0", s1[0], 64'h1A);
            chk("bp_order1", s1[1], 64'h1B);
            chk("bp_order2", s1[2], 64'h1C);
        end

        // Random traffic with a mid-burst reset
        do_reset(4'b0000);
        for (int c = 0; c < 1500; c++) begin
            if (c == 700) begin
                do_reset(4'b1111);
                chk("midrst_wena", 64'(wena), 64'd0);
                chk("midrst_src_ready", 64'(src_ready), 64'hF);
                chk("midrst_idle", 64'(idle), 64'd1);
            end
            for (int i = 0; i < 4; i++) begin
                a[i] = 6'($urandom_range(0, 7));
                v[i] = {$urandom, $urandom};
            end
            cycle(4'($urandom), a, v, acc);
        end
        for (int c = 0; c < 12; c++) cycle(4'b0000, '0, '0, acc);
        chk("drain_idle", 64'(idle), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
